// File: rtl/vga_pkg.sv
// Shared VGA definitions: register offsets, copper opcodes and copper FSM states.
package vga_pkg;

   localparam logic [7:0] VGA_REG_CTRL       = 8'h00;
   localparam logic [7:0] VGA_REG_STATUS     = 8'h04;
   localparam logic [7:0] VGA_REG_HTIMING    = 8'h08;
   localparam logic [7:0] VGA_REG_VTIMING    = 8'h0C;
   localparam logic [7:0] VGA_REG_FB_BASE    = 8'h10;
   localparam logic [7:0] VGA_REG_FB_STRIDE  = 8'h14;
   localparam logic [7:0] VGA_REG_WAIT       = 8'h18;
   localparam logic [7:0] VGA_REG_PAL_IDX    = 8'h1C;
   localparam logic [7:0] VGA_REG_PAL_DATA   = 8'h20;
   localparam logic [7:0] VGA_REG_BG_COLOR   = 8'h24;
   localparam logic [7:0] VGA_REG_SCROLL_X   = 8'h28;
   localparam logic [7:0] VGA_REG_SCROLL_Y   = 8'h2C;
   localparam logic [7:0] VGA_REG_IRQ_EN     = 8'h30;
   localparam logic [7:0] VGA_REG_IRQ_STAT   = 8'h34;
   localparam logic [7:0] VGA_REG_LINE_CMP   = 8'h38;
   localparam logic [7:0] VGA_REG_CUR_LINE   = 8'h3C;
   localparam logic [7:0] VGA_REG_CURSOR_CTL = 8'h40;
   localparam logic [7:0] VGA_REG_CURSOR_X   = 8'h44;
   localparam logic [7:0] VGA_REG_CURSOR_Y   = 8'h48;
   localparam logic [7:0] VGA_REG_CURSOR_CLR = 8'h4C;
   localparam logic [7:0] VGA_REG_CURSOR_POS = 8'h50;

   localparam logic [7:0] COPPER_OP_HALT = 8'hFF;
   localparam logic [7:0] COPPER_OP_JUMP = 8'hFE;

   typedef enum logic [1:0] {
      CU_IDLE,
      CU_FETCH,
      CU_DECODE,
      CU_WRITE
   } copper_state_e;

endpackage

// File: rtl/vga_copper.sv
// Copper: walks a display list in external memory and turns each command into a
// single-beat Wishbone write to the VGA register block, stalling until the write is acked.
module vga_copper
   import vga_pkg::*;
#(
   parameter int         LIST_AW   = 8,
   parameter logic [7:0] WB_BASE   = 8'h04,
   parameter int         TIMEOUT_W = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [LIST_AW-1:0] start_addr,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic               list_rd_o,
   output logic [LIST_AW-1:0] list_addr_o,
   input  logic [39:0]        list_data_i,
   output logic [31:0]        wb_addr_o,
   output logic [31:0]        wb_data_o,
   output logic [3:0]         wb_sel_o,
   output logic               wb_we_o,
   output logic               wb_stb_o,
   output logic               wb_cyc_o,
   input  logic               wb_ack_i
);

   // Last count before saturation: the write gives up after 2**TIMEOUT_W-1 unacked cycles.
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   copper_state_e        state_q, state_d;
   logic [LIST_AW-1:0]   pc_q, pc_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          data_q, data_d;
   logic                 stb_q, stb_d;
   logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
   logic [7:0]           op;

   assign op = list_data_i[39:32];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CU_IDLE;
         pc_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         stb_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         stb_q   <= stb_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = error_q;
      addr_d  = addr_q;
      data_d  = data_q;
      stb_d   = stb_q;
      tmo_d   = tmo_q;

      case (state_q)
         CU_IDLE: begin
            if (start) begin
               pc_d    = start_addr;
               error_d = 1'b0;
               busy_d  = 1'b1;
               state_d = CU_FETCH;
            end
         end
         CU_FETCH: begin
            state_d = CU_DECODE;
         end
         CU_DECODE: begin
            if (op == COPPER_OP_HALT) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = CU_IDLE;
            end else if (op == COPPER_OP_JUMP) begin
               pc_d    = list_data_i[LIST_AW-1:0];
               state_d = CU_FETCH;
            end else begin
               addr_d  = {WB_BASE, 16'h0000, op};
               data_d  = list_data_i[31:0];
               stb_d   = 1'b1;
               tmo_d   = '0;
               state_d = CU_WRITE;
            end
         end
         CU_WRITE: begin
            if (wb_ack_i) begin
               stb_d   = 1'b0;
               pc_d    = pc_q + 1'b1;
               state_d = CU_FETCH;
            end else if (tmo_q == TMO_LAST) begin
               stb_d   = 1'b0;
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = CU_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            state_d = CU_IDLE;
         end
      endcase

      // Abort overrides everything, including an ack landing in the same cycle.
      if (abort && (state_q != CU_IDLE)) begin
         state_d = CU_IDLE;
         pc_d    = pc_q;
         stb_d   = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         error_d = error_q;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign list_rd_o   = (state_q == CU_FETCH);
   assign list_addr_o = pc_q;
   assign wb_addr_o   = addr_q;
   assign wb_data_o   = data_q;
   assign wb_sel_o    = 4'hF;
   assign wb_we_o     = stb_q;
   assign wb_stb_o    = stb_q;
   assign wb_cyc_o    = stb_q;

endmodule

// File: tb/tb_vga_copper.sv
// Self-checking bench for vga_copper: list memory, configurable-latency responder,
// bus monitor and a list-interpreter reference model.
module tb_vga_copper;

   localparam int AW    = 4;
   localparam int TW    = 10;
   localparam int DEPTH = 16;
   localparam int LIMIT = 4000;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic          abort;
   logic          busy, done, error;
   logic          list_rd_o;
   logic [AW-1:0] list_addr_o;
   logic [39:0]   list_data;
   logic [31:0]   wb_addr_o, wb_data_o;
   logic [3:0]    wb_sel_o;
   logic          wb_we_o, wb_stb_o, wb_cyc_o;
   logic          wb_ack_i;

   logic [39:0]   mem [DEPTH];
   logic [63:0]   exp_q [$];
   logic [63:0]   got_q [$];

   int total = 0;
   int bad   = 0;

   int ack_delay = 0;
   bit never_ack = 1'b0;
   int rcnt;

   bit mon_clr = 1'b0;
   int done_cnt, unstable, overlap, sig_err, hi_len, last_hi, low_len, min_gap;
   bit seen_write, prev_cyc;
   logic [31:0] pa, pd;

   vga_copper #(.LIST_AW(AW), .WB_BASE(8'h04), .TIMEOUT_W(TW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_addr  (start_addr),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .list_rd_o   (list_rd_o),
      .list_addr_o (list_addr_o),
      .list_data_i (list_data),
      .wb_addr_o   (wb_addr_o),
      .wb_data_o   (wb_data_o),
      .wb_sel_o    (wb_sel_o),
      .wb_we_o     (wb_we_o),
      .wb_stb_o    (wb_stb_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_ack_i    (wb_ack_i)
   );

   always #5 clk = ~clk;

   // Synchronous-read list memory
   always @(posedge clk) begin
      if (list_rd_o) list_data <= mem[list_addr_o];
   end

   // Responder: one-cycle ack ack_delay+1 cycles after cyc rises, or never
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_ack_i <= 1'b0;
         rcnt     <= 0;
      end else begin
         wb_ack_i <= 1'b0;
         if (wb_cyc_o && !wb_ack_i && !never_ack) begin
            if (rcnt >= ack_delay) begin
               wb_ack_i <= 1'b1;
               rcnt     <= 0;
            end else begin
               rcnt <= rcnt + 1;
            end
         end else if (!wb_cyc_o) begin
            rcnt <= 0;
         end
      end
   end

   // Bus monitor: collects completed writes and protocol statistics
   always @(negedge clk) begin
      if (mon_clr) begin
         got_q.delete();
         done_cnt   = 0;
         unstable   = 0;
         overlap    = 0;
         sig_err    = 0;
         hi_len     = 0;
         last_hi    = 0;
         low_len    = 0;
         min_gap    = 1000;
         seen_write = 1'b0;
         prev_cyc   = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (wb_cyc_o && list_rd_o) overlap++;
         if (wb_we_o !== wb_cyc_o || wb_sel_o !== 4'hF) sig_err++;
         if (wb_cyc_o) begin
            if (prev_cyc && (wb_addr_o !== pa || wb_data_o !== pd)) unstable++;
            if (!prev_cyc && seen_write && low_len < min_gap) min_gap = low_len;
            hi_len++;
            low_len = 0;
            if (wb_ack_i) begin
               got_q.push_back({wb_addr_o, wb_data_o});
               seen_write = 1'b1;
            end
         end else begin
            if (prev_cyc) last_hi = hi_len;
            hi_len = 0;
            low_len++;
         end
         pa       = wb_addr_o;
         pd       = wb_data_o;
         prev_cyc = wb_cyc_o;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearMon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic fillHalt();
      for (int i = 0; i < DEPTH; i++) mem[i] = {8'hFF, 32'h0};
   endtask

   // Reference: interpret the list as a program and list the writes it should produce
   task automatic modelRun(input int sa, output bit halted);
      int         pc;
      logic [7:0] opc;
      logic [39:0] cmd;
      pc = sa;
      halted = 1'b0;
      exp_q.delete();
      for (int s = 0; s < 40; s++) begin
         cmd = mem[pc];
         opc = cmd[39:32];
         if (opc == 8'hFF) begin
            halted = 1'b1;
            break;
         end else if (opc == 8'hFE) begin
            pc = int'(cmd[AW-1:0]);
         end else begin
            exp_q.push_back({32'h0400_0000 + {24'h0, opc}, cmd[31:0]});
            pc = (pc + 1) % DEPTH;
         end
      end
   endtask

   // Start the list at sa and run until busy falls (bounded)
   task automatic applyStimulus(input int sa, output int first_stb);
      int cycles;
      clearMon();
      start_addr = AW'(sa);
      start      = 1'b1;
      cycles     = 0;
      first_stb  = -1;
      do begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) start = 1'b0;
         if (first_stb < 0 && wb_cyc_o) first_stb = cycles;
      end while ((busy || cycles < 2) && cycles < LIMIT);
      checkOutput("run_ends", 64'(cycles < LIMIT), 64'd1);
      @(negedge clk);
   endtask

   task automatic compareWrites(input string tag);
      checkOutput({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         checkOutput({tag, "_wr"}, got_q[i], exp_q[i]);
   endtask

   task automatic waitCyc();
      int n;
      n = 0;
      while (!wb_cyc_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("cyc_seen", 64'(wb_cyc_o), 64'd1);
   endtask

   initial begin
      int  first;
      bit  halted;
      int  tries;
      int  r;
      start = 1'b0;
      abort = 1'b0;
      start_addr = '0;
      fillHalt();
      reset = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("rst_ctrl", 64'({busy, done, error, list_rd_o, wb_stb_o, wb_cyc_o, wb_we_o}), 64'd0);
      checkOutput("rst_laddr", 64'(list_addr_o), 64'd0);
      checkOutput("rst_wbaddr", 64'(wb_addr_o), 64'd0);
      checkOutput("rst_wbdata", 64'(wb_data_o), 64'd0);
      checkOutput("rst_sel", 64'(wb_sel_o), 64'hF);
      reset = 1'b0;
      @(negedge clk);

      // Single write then halt
      mem[0] = {8'h00, 32'h1234_5678};
      modelRun(0, halted);
      applyStimulus(0, first);
      compareWrites("t1");
      checkOutput("t1_latency", 64'(first), 64'd3);
      checkOutput("t1_done", 64'(done_cnt), 64'd1);
      checkOutput("t1_busy", 64'(busy), 64'd0);
      checkOutput("t1_error", 64'(error), 64'd0);
      checkOutput("t1_sig", 64'(sig_err), 64'd0);

      // Long-stalled blocking write
      fillHalt();
      mem[0] = {8'h18, 32'hAABB_CCDD};
      mem[1] = {8'h1C, 32'h0000_0011};
      ack_delay = 500;
      modelRun(0, halted);
      applyStimulus(0, first);
      compareWrites("t2");
      checkOutput("t2_stable", 64'(unstable), 64'd0);
      checkOutput("t2_nofetch", 64'(overlap), 64'd0);
      checkOutput("t2_hold", 64'(last_hi), 64'd502);
      checkOutput("t2_gap", 64'(min_gap >= 2), 64'd1);
      checkOutput("t2_error", 64'(error), 64'd0);
      checkOutput("t2_done", 64'(done_cnt), 64'd1);
      ack_delay = 0;

      // Ack timeout
      fillHalt();
      mem[0] = {8'h20, 32'h0000_DEAD};
      never_ack = 1'b1;
      applyStimulus(0, first);
      checkOutput("t3_error", 64'(error), 64'd1);
      checkOutput("t3_busy", 64'(busy), 64'd0);
      checkOutput("t3_done", 64'(done_cnt), 64'd0);
      checkOutput("t3_nwr", 64'(got_q.size()), 64'd0);
      checkOutput("t3_hold", 64'(last_hi), 64'((1 << TW) - 1));
      never_ack = 1'b0;
      fillHalt();
      applyStimulus(0, first);
      checkOutput("t3_errclr", 64'(error), 64'd0);

      // pc wrap 15 -> 0
      fillHalt();
      mem[15] = {8'h0C, 32'h0000_0055};
      modelRun(15, halted);
      applyStimulus(15, first);
      compareWrites("t4");
      checkOutput("t4_done", 64'(done_cnt), 64'd1);

      // Jump skips a command
      fillHalt();
      mem[0] = {8'h04, 32'h0000_000A};
      mem[1] = {8'hFE, 32'h0000_0003};
      mem[2] = {8'h08, 32'h0000_000B};
      modelRun(0, halted);
      applyStimulus(0, first);
      compareWrites("t5");
      checkOutput("t5_done", 64'(done_cnt), 64'd1);

      // Abort mid-write
      fillHalt();
      mem[0] = {8'h30, 32'h1};
      mem[1] = {8'h34, 32'h2};
      mem[5] = {8'h3C, 32'h9};
      never_ack = 1'b1;
      clearMon();
      start_addr = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitCyc();
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("t6_abort_cyc", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
      checkOutput("t6_abort_busy", 64'(busy), 64'd0);
      checkOutput("t6_abort_err", 64'(error), 64'd0);
      @(negedge clk);
      checkOutput("t6_abort_done", 64'(done_cnt), 64'd0);
      never_ack = 1'b0;

      // Start while busy is ignored
      ack_delay = 20;
      clearMon();
      start_addr = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start_addr = 4'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < LIMIT && busy; n++) @(negedge clk);
      @(negedge clk);
      modelRun(0, halted);
      compareWrites("t6_ign");
      modelRun(5, halted);
      applyStimulus(5, first);
      compareWrites("t6_acc");

      // Abort in the same cycle as ack
      ack_delay = 6;
      clearMon();
      start_addr = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 50 && !wb_ack_i; n++) @(negedge clk);
      checkOutput("t6_ack_seen", 64'(wb_ack_i), 64'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("t6_aa_busy", 64'(busy), 64'd0);
      checkOutput("t6_aa_cyc", 64'(wb_cyc_o), 64'd0);
      repeat (4) @(negedge clk);
      checkOutput("t6_aa_nwr", 64'(got_q.size()), 64'd1);
      checkOutput("t6_aa_done", 64'(done_cnt), 64'd0);

      // Reset mid-write
      ack_delay = 100;
      start_addr = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitCyc();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("t6_rst_cyc", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
      checkOutput("t6_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Randomized lists against the reference model
      for (int it = 0; it < 25; it++) begin
         tries = 0;
         do begin
            for (int i = 0; i < DEPTH; i++) begin
               r = int'($urandom % 10);
               if (r == 0)      mem[i] = {8'hFF, 32'h0};
               else if (r == 1) mem[i] = {8'hFE, 32'($urandom)};
               else             mem[i] = {8'($urandom % 254), 32'($urandom)};
            end
            start_addr = 4'($urandom % DEPTH);
            modelRun(int'(start_addr), halted);
            tries++;
         end while (!halted && tries < 50);
         if (!halted) begin
            fillHalt();
            modelRun(int'(start_addr), halted);
         end
         ack_delay = int'($urandom % 4);
         applyStimulus(int'(start_addr), first);
         compareWrites("rnd");
         checkOutput("rnd_done", 64'(done_cnt), 64'd1);
         checkOutput("rnd_error", 64'(error), 64'd0);
         checkOutput("rnd_stable", 64'(unstable), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
